// File: rtl/param_register_file_pkg.sv
// Shared types and default sizes for the parametrised register file.
package rf_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    localparam int RF_DEF_WIDTH = 4;
    localparam int RF_DEF_DEPTH = 4;

endpackage

// File: rtl/param_register_file_clear_fsm.sv
// Bulk-clear sequencer: walks a pointer over every entry, one per clock,
// and tells the array which entry to zero.
module rf_clear_fsm
    import rf_pkg::*;
#(
    parameter int DEPTH  = RF_DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RF_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_we  = 1'b0;
        case (state_q)
            RF_IDLE: begin
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    ptr_d   = '0;
                end
            end
            RF_CLEAR: begin
                // clr_req is deliberately not looked at here: no restart or extension.
                clr_we = 1'b1;
                if (ptr_q == LAST) begin
                    state_d = RF_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = RF_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    assign busy     = (state_q == RF_CLEAR);
    assign clr_addr = ptr_q;

endmodule

// File: rtl/param_register_file.sv
// DEPTH x WIDTH register file: one synchronous write port, two combinational
// read ports, optional hardwired-zero entry 0, bulk clear engine.
// Optional write-to-read forwarding when PARAM_REGFILE_BYPASS_EN is defined.
module param_register_file
    import rf_pkg::*;
#(
    parameter  int WIDTH    = RF_DEF_WIDTH,
    parameter  int DEPTH    = RF_DEF_DEPTH,
    parameter  int ZERO_REG = 0,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [WIDTH-1:0]  rdata0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata1,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_drop
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic                        clr_we;
    logic [ADDR_W-1:0]           clr_addr;
    logic                        wr_acc;

    rf_clear_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wr_acc  = we && !busy && !(ZERO_EN && (waddr == '0));
    assign wr_drop = we && !wr_acc;

    // clr_we and wr_acc are mutually exclusive since wr_acc requires !busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_acc) begin
            mem_q[waddr] <= wdata;
        end
    end

    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] ra);
        logic [WIDTH-1:0] v;
        v = mem_q[ra];
`ifdef PARAM_REGFILE_BYPASS_EN
        if (wr_acc && (waddr == ra)) v = wdata;
`endif
        // Zero entry wins over forwarding.
        if (ZERO_EN && (ra == '0)) v = '0;
        return v;
    endfunction

    always_comb begin
        rdata0 = read_port(raddr0);
        rdata1 = read_port(raddr1);
    end

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench: instance A (W4/D4, no zero reg), instance B (W8/D8, zero reg).
module tb_param_register_file;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=4, DEPTH=4, ZERO_REG=0
    logic       a_we, a_clr, a_busy, a_drop;
    logic [1:0] a_wa, a_ra0, a_ra1;
    logic [3:0] a_wd, a_rd0, a_rd1;

    // Instance B: WIDTH=8, DEPTH=8, ZERO_REG=1
    logic       b_we, b_clr, b_busy, b_drop;
    logic [2:0] b_wa, b_ra0, b_ra1;
    logic [7:0] b_wd, b_rd0, b_rd1;

    param_register_file #(.WIDTH(4), .DEPTH(4), .ZERO_REG(0)) u_a (
        .clk(clk), .rst_n(rst_n), .we(a_we), .waddr(a_wa), .wdata(a_wd),
        .raddr0(a_ra0), .rdata0(a_rd0), .raddr1(a_ra1), .rdata1(a_rd1),
        .clr_req(a_clr), .busy(a_busy), .wr_drop(a_drop)
    );

    param_register_file #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1)) u_b (
        .clk(clk), .rst_n(rst_n), .we(b_we), .waddr(b_wa), .wdata(b_wd),
        .raddr0(b_ra0), .rdata0(b_rd0), .raddr1(b_ra1), .rdata1(b_rd1),
        .clr_req(b_clr), .busy(b_busy), .wr_drop(b_drop)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       we;
        logic [1:0] wa;
        logic [3:0] wd;
        logic [1:0] ra0;
        logic [1:0] ra1;
        logic [3:0] e_rd0;
        logic [3:0] e_rd1;
        logic       e_drop;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // Reads show state before the edge; no vector reads the address it writes.
        vecs[0] = '{1'b1, 2'd1, 4'hF, 2'd2, 2'd3, 4'h0, 4'h0, 1'b0};
        vecs[1] = '{1'b1, 2'd2, 4'h5, 2'd1, 2'd0, 4'hF, 4'h0, 1'b0};
        vecs[2] = '{1'b0, 2'd0, 4'h0, 2'd1, 2'd2, 4'hF, 4'h5, 1'b0};
        vecs[3] = '{1'b1, 2'd3, 4'hA, 2'd2, 2'd2, 4'h5, 4'h5, 1'b0};
        vecs[4] = '{1'b1, 2'd0, 4'h3, 2'd3, 2'd1, 4'hA, 4'hF, 1'b0};
        vecs[5] = '{1'b0, 2'd0, 4'h0, 2'd0, 2'd3, 4'h3, 4'hA, 1'b0};
        vecs[6] = '{1'b1, 2'd1, 4'h6, 2'd0, 2'd2, 4'h3, 4'h5, 1'b0};
        vecs[7] = '{1'b0, 2'd0, 4'h0, 2'd1, 2'd1, 4'h6, 4'h6, 1'b0};

        a_we = 0; a_wa = 0; a_wd = 0; a_ra0 = 0; a_ra1 = 0; a_clr = 0;
        b_we = 0; b_wa = 0; b_wd = 0; b_ra0 = 0; b_ra1 = 0; b_clr = 0;

        // Reset state
        #12;
        a_ra0 = 2'd1; a_ra1 = 2'd3; b_ra0 = 3'd5; b_ra1 = 3'd7;
        #1;
        check("rst_a_rd0", a_rd0, 0);
        check("rst_a_rd1", a_rd1, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_b_rd0", b_rd0, 0);
        check("rst_b_busy", b_busy, 0);
        rst_n = 1'b1;
        tick();

        // Table-driven write/dual-read on A
        for (int i = 0; i < 8; i++) begin
            a_we = vecs[i].we; a_wa = vecs[i].wa; a_wd = vecs[i].wd;
            a_ra0 = vecs[i].ra0; a_ra1 = vecs[i].ra1;
            #1;
            check($sformatf("vec%0d_rd0", i), a_rd0, vecs[i].e_rd0);
            check($sformatf("vec%0d_rd1", i), a_rd1, vecs[i].e_rd1);
            check($sformatf("vec%0d_drop", i), a_drop, vecs[i].e_drop);
            tick();
        end
        a_we = 0;

        // Hardwired zero on B
        b_we = 1; b_wa = 3'd0; b_wd = 8'hAA; b_ra0 = 3'd0;
        #1;
        check("zr_drop", b_drop, 1);
        check("zr_rd0_same", b_rd0, 8'h00);
        tick();
        b_we = 0;
        #1;
        check("zr_rd0_after", b_rd0, 8'h00);
        b_we = 1; b_wa = 3'd3; b_wd = 8'hAA;
        #1;
        check("zr_wr3_drop", b_drop, 0);
        tick();
        b_we = 0; b_ra0 = 3'd3;
        #1;
        check("zr_rd3", b_rd0, 8'hAA);

        // Preload B entries 1..7 with 0x11
        for (int k = 1; k < 8; k++) begin
            b_we = 1; b_wa = 3'(k); b_wd = 8'h11;
            tick();
        end
        b_we = 0;

        // Bulk clear; a write in the same cycle as clr_req is accepted then cleared
        b_clr = 1; b_we = 1; b_wa = 3'd5; b_wd = 8'h22;
        #1;
        check("clr_start_drop", b_drop, 0);
        check("clr_start_busy", b_busy, 0);
        tick();
        b_clr = 0; b_we = 0;
        for (int n = 0; n < 8; n++) begin
            b_ra0 = 3'(n == 0 ? 0 : n - 1);
            b_ra1 = 3'(n);
            if (n == 2) begin b_we = 1; b_wa = 3'd5; b_wd = 8'h33; end
            if (n == 3) b_clr = 1;
            #1;
            check($sformatf("clr_busy_c%0d", n), b_busy, 1);
            check($sformatf("clr_prev_c%0d", n), b_rd0, 0);
            check($sformatf("clr_cur_c%0d", n), b_rd1,
                  (n == 0) ? 32'h0 : (n == 5) ? 32'h22 : 32'h11);
            if (n == 2) check("clr_wr_drop", b_drop, 1);
            tick();
            b_we = 0; b_clr = 0;
        end
        check("clr_busy_end", b_busy, 0);
        for (int k = 0; k < 8; k++) begin
            b_ra0 = 3'(k);
            #1;
            check($sformatf("clr_zero_e%0d", k), b_rd0, 0);
        end
        b_we = 1; b_wa = 3'd4; b_wd = 8'h5A;
        #1;
        check("post_clr_drop", b_drop, 0);
        tick();
        b_we = 0; b_ra0 = 3'd4;
        #1;
        check("post_clr_rd4", b_rd0, 8'h5A);

        // Short clear on A, covering entry 0 (no zero reg) and busy length
        a_ra0 = 2'd0; a_ra1 = 2'd3;
        #1;
        check("a_pre_clr_rd0", a_rd0, 4'h3);
        a_clr = 1;
        tick();
        a_clr = 0;
        begin
            int busy_cnt = 0;
            for (int c = 0; c < 20 && a_busy; c++) begin
                busy_cnt++;
                tick();
            end
            check("a_busy_len", busy_cnt, 4);
        end
        #1;
        check("a_clr_rd0", a_rd0, 0);
        check("a_clr_rd3", a_rd1, 0);

        // Reset in the middle of a clear on A (reload first)
        a_we = 1; a_wa = 2'd3; a_wd = 4'h9;
        tick();
        a_we = 0;
        a_clr = 1;
        tick();
        a_clr = 0;
        tick(); tick();
        #1;
        check("mid_busy_before", a_busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_busy_rst", a_busy, 0);
        check("mid_rd3_rst", a_rd1, 0);
        #2;
        rst_n = 1'b1;
        tick();
        a_clr = 1;
        tick();
        a_clr = 0;
        #1;
        check("mid_restart_busy", a_busy, 1);
        begin
            int guard = 0;
            while (a_busy && guard < 20) begin
                guard++;
                tick();
            end
            check("mid_restart_done", a_busy, 0);
        end

        // Forwarding check: entry 2 is 0 here
        a_we = 1; a_wa = 2'd2; a_wd = 4'h7; a_ra0 = 2'd2;
        #1;
`ifdef PARAM_REGFILE_BYPASS_EN
        check("byp_same", a_rd0, 4'h7);
`else
        check("byp_same", a_rd0, 4'h0);
`endif
        tick();
        a_we = 0;
        #1;
        check("byp_next", a_rd0, 4'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised successor of the lab register file.
- Provides DEPTH entries of WIDTH bits, one synchronous write port, and two combinational read ports.
- Supports an optional hardwired-zero entry 0.
- Includes a sequential bulk-clear engine that zeroes the array one entry per clock.
- Sits between the switch/decoder front end (or the CPU decode stage) and the datapath/LED display.

Parameters:
- WIDTH, 4: data width of each entry.
- DEPTH, 4: number of entries; power of two, at least 2.
- ADDR_W, $clog2(DEPTH): address width; derived, not overridden.
- ZERO_REG, 0: when 1, entry 0 always reads 0 and writes to it are discarded.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  WIDTH  write data.
- raddr0  in  ADDR_W  read port 0 address.
- rdata0  out  WIDTH  read port 0 data (combinational).
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  WIDTH  read port 1 data (combinational).
- clr_req  in  1  single-cycle request to start a bulk clear.
- busy  out  1  high while the bulk clear is running.
- wr_drop  out  1  combinational; high when we=1 but the write is discarded.

Behaviour:
- Reset (rst_n=0, asynchronous): all entries 0, state IDLE, busy=0, clear pointer 0. rdata0/rdata1 therefore read 0.
- Write acceptance:
  - accepted = we & ~busy & ~(ZERO_REG & waddr==0).
  - On the clk edge an accepted write stores wdata at waddr.
  - wr_drop = we & ~accepted.
- Read: rdataN = mem[raddrN]; when ZERO_REG=1 and raddrN==0, rdataN = 0. Zero-cycle latency; a write becomes visible the cycle after its edge.
- Same-address reads: both ports may read the same address simultaneously, and both see the same value.
- FSM IDLE:
  - clr_req=1 moves to CLEAR at the next edge; busy=1 from that edge; pointer=0.
  - A write presented in the same cycle as clr_req is accepted, and is then overwritten by the clear.
- FSM CLEAR:
  - Each edge writes 0 to mem[pointer] and increments the pointer.
  - When pointer==DEPTH-1, that entry is cleared, the FSM returns to IDLE, busy=0, and the pointer wraps to 0.
  - Total: exactly DEPTH cycles with busy=1.
- During CLEAR:
  - clr_req is ignored (no restart or extension).
  - User writes are dropped.
  - Reads return current contents, including partially cleared contents.
- Reset mid-CLEAR: immediate return to IDLE with all entries 0.
- Widths: no arithmetic on data. The pointer is ADDR_W bits and wraps naturally.

Optional Feature:
- Macro: PARAM_REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If the write is accepted and waddr==raddrN, rdataN = wdata in the same cycle. The ZERO_REG rule still takes precedence.
- Undefined: rdataN shows the old value until after the edge.
- busy and wr_drop behaviour is identical in both builds.

Decomposition:
- Package rf_pkg:
  - state enum {RF_IDLE, RF_CLEAR}.
  - default WIDTH/DEPTH constants.
- Sub-module rf_clear_fsm owns the state, pointer and busy. It outputs clr_we and clr_addr to the array in param_register_file.

Test Plan:
1. Reset then read (WIDTH=4, DEPTH=4): rst_n=0 → rdata0=rdata1=0, busy=0.
2. Write, then dual read: write 0xF to addr 1, then 0x5 to addr 2; set raddr0=1, raddr1=2 → rdata0=0xF, rdata1=0x5.
3. Hardwired zero (ZERO_REG=1, WIDTH=8, DEPTH=8):
   - we=1, waddr=0, wdata=0xAA → wr_drop=1, rdata0(raddr0=0)=0x00.
   - A write to addr 3 reads back 0xAA.
4. Bulk clear (DEPTH=8, all entries preloaded with 0x11):
   - 1-cycle clr_req → busy high for exactly 8 cycles.
   - Entry k reads 0 from cycle k+1 after start; all entries read 0 after busy falls.
   - A write to addr 5 during busy → wr_drop=1, entry stays 0.
   - A second clr_req mid-clear does not extend busy.
5. Reset mid-clear: assert rst_n=0 at cycle 3 of CLEAR → busy=0 immediately, all reads 0, FSM accepts a new clr_req afterwards.
6. Bypass: write 0x7 to addr 2 with raddr0=2.
   - PARAM_REGFILE_BYPASS_EN defined: rdata0=0x7 in the same cycle.
   - Undefined: old value in that cycle, 0x7 in the next.
